serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Bit-serial subtractor controller that computes `a - b - bin` over WIDTH cycles. It time-multiplexes a single one-bit full-subtractor cell (difference = a^b^borrow, borrow = ~a&b | ~(a^b)&borrow) across all operand bits, LSB first. Operands enter and results leave through valid/ready handshakes. It is used where a WIDTH-bit ripple subtractor costs too much area and multi-cycle latency is acceptable.

## Interface
- `WIDTH`, default 8, operand and result width; legal range 2..64.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand set present on `a`/`b`/`bin`.
- `in_ready`  out  1  controller can accept operands; equals (state==IDLE).
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  initial borrow-in.
- `out_valid`  out  1  result held on `diff`/`bout`.
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  WIDTH  difference, modulo 2^WIDTH.
- `bout`  out  1  borrow out of the MSB (1 = unsigned underflow).
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- **FSM states:** IDLE, RUN, DONE. Registers: shift registers `a_sh` and `b_sh`, result shift register `d_sh`, borrow flop `br`, bit counter `cnt` of width clog2(WIDTH).
- **IDLE:**
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid` & `in_ready`: load `a_sh`=`a`, `b_sh`=`b`, `br`=`bin`, `cnt`=0, then go to RUN.
  - Inputs are sampled only on the accepting edge.
- **RUN:** each cycle, do the following:
  - Compute one bit from `a_sh[0]`, `b_sh[0]` and `br`.
  - Shift `a_sh` and `b_sh` right by one.
  - Shift the result bit into the MSB of `d_sh`, shifting it right.
  - Update `br` to the cell's borrow and increment `cnt`.
  - On the cycle with `cnt`==WIDTH-1, go to DONE.
  - `in_ready`=0. `in_valid` is ignored.
- **DONE:**
  - `out_valid`=1; `diff`=`d_sh` and `bout`=`br` are held stable.
  - When `out_valid` & `out_ready`: go to IDLE.
- **Arithmetic:** the result equals (`a` - `b` - `bin`) mod 2^WIDTH. `bout`=1 exactly when `a` < `b` + `bin` (unsigned compare).
- **No overlap:** a new operand set is never accepted in the same cycle a result is consumed.

## Timing
- **Reset values:** while `rst_n` is low, immediately and independent of `clk`:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0; all internal registers are 0.
- **Latency:** operands are accepted at edge T0. Bits 0..WIDTH-1 are processed at edges T1..TWIDTH. `out_valid` rises after edge TWIDTH.
- **Throughput:** minimum WIDTH+2 cycles per operation (accept, WIDTH RUN cycles, result handshake).
- **Backpressure:** with `out_ready` low, DONE holds indefinitely with outputs unchanged.
- **Reset mid-RUN or mid-DONE:** the operation is abandoned and no result is produced. The first accept after `rst_n` rises starts a clean operation.
- **Simultaneous events:** `in_valid` high in RUN or DONE has no effect. `out_ready` high outside DONE has no effect.

## Configuration
- **`SERIAL_SUB_OVF_EN` defined:**
  - Port `ovf` exists.
  - A flop captures the borrow into the MSB during the last RUN cycle.
  - `ovf` = that borrow XOR `bout`. It is valid and held in DONE and is 0 otherwise.
- **Not defined:** port `ovf` and its flop are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, `a`=0x35, `b`=0x12, `bin`=0 → `diff`=0x23, `bout`=0. `out_valid` rises exactly 8 cycles after the accepting edge.
- `a`=0x00, `b`=0x01, `bin`=0 → `diff`=0xFF, `bout`=1. `a`=0x10, `b`=0x10, `bin`=1 → `diff`=0xFF, `bout`=1.
- With `SERIAL_SUB_OVF_EN` defined, `a`=0x80, `b`=0x01 → `diff`=0x7F, `bout`=0, `ovf`=1. `a`=0x05, `b`=0x03 → `ovf`=0.
- Hold `out_ready` low for 5 cycles in DONE while pulsing `in_valid` with new operands → `diff`/`bout` stay unchanged, `in_ready` stays 0, and the new operands are not captured. Raise `out_ready` → return to IDLE, then the next operands are accepted.
- Assert `rst_n` low during the 4th RUN cycle → all outputs go to reset values immediately. After release, 0x0A-0x03 yields 0x07 with correct latency.
- Back-to-back random operands for 1000 operations with random `out_ready` stalls → every result matches (`a`-`b`-`bin`) mod 256 and the computed borrow.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin using one full-subtractor cell, LSB first, with valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_b;
    logic             last_bit;

    always_comb begin
        cell_d   = a_sh[0] ^ b_sh[0] ^ br;
        cell_b   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

`ifdef SERIAL_SUB_OVF_EN
    logic msb_bin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            msb_bin <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= {cell_d, d_sh[WIDTH-1:1]};
                    br   <= cell_b;
                    cnt  <= cnt + 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // br still holds the borrow into the MSB on the final cell cycle
                    if (last_bit) msb_bin <= br;
`endif
                    if (last_bit) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = d_sh;
    assign bout      = br;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = (state == DONE) & (msb_bin ^ br);
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and randomised checks of serial_subtractor_ctrl at WIDTH=8.
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Full transaction: accept, wait for result, optionally stall, consume.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input int stall, input string tag);
        int         n;
        logic [8:0] m;
        logic [8:0] s;
        m = {1'b0, ta} - {1'b0, tb} - {8'd0, tbin};
        s = {ta[7], ta} - {tb[7], tb} - {8'd0, tbin};
        @(negedge clk);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        bin      = 1'($urandom);
        check({tag, "_busy"}, in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, 8);
        check({tag, "_diff"}, diff, m[7:0]);
        check({tag, "_bout"}, bout, m[8]);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf, s[8] ^ s[7]);
`endif
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            check({tag, "_stall_diff"}, diff, m[7:0]);
            check({tag, "_stall_valid"}, out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, in_ready, 1'b1);
        check({tag, "_novalid"}, out_valid, 1'b0);
    endtask

    initial begin
        int         n;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h35, 8'h12, 1'b0, 0, "t35_12");
        do_op(8'h00, 8'h01, 1'b0, 0, "t00_01");
        do_op(8'h10, 8'h10, 1'b1, 0, "t10_10_b");
        do_op(8'h80, 8'h01, 1'b0, 0, "t80_01");
        do_op(8'h05, 8'h03, 1'b0, 0, "t05_03");
        do_op(8'hFF, 8'hFF, 1'b1, 2, "tFF_FF_b");

        // Backpressure: result must hold and in_valid must be ignored in DONE.
        @(negedge clk);
        a        = 8'h40;
        b        = 8'h21;
        bin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_lat", n, 8);
        check("bp_diff0", diff, 8'h1E);
        check("bp_bout0", bout, 1'b0);
        a        = 8'hAA;
        b        = 8'h55;
        bin      = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold_diff", diff, 8'h1E);
            check("bp_hold_bout", bout, 1'b0);
            check("bp_hold_ready", in_ready, 1'b0);
            check("bp_hold_valid", out_valid, 1'b1);
            in_valid = ~in_valid;
        end
        a         = 8'h0F;
        b         = 8'h01;
        bin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_ready", in_ready, 1'b1);
        check("bp_release_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_accept", in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_next_lat", n, 8);
        check("bp_next_diff", diff, 8'h0E);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset asserted during the 4th RUN cycle.
        @(negedge clk);
        a        = 8'hC3;
        b        = 8'h5A;
        bin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_diff", diff, 8'h00);
        check("mid_rst_bout", bout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_no_result", out_valid, 1'b0);
        do_op(8'h0A, 8'h03, 1'b0, 0, "t0A_03");

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            do_op(ra, rb, rbin, int'($urandom_range(0, 3)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
